// File: rtl/axis_frame_sink_if.sv
// AXI-Stream pixel channel between an upstream source and the frame sink.
// The DUT takes the slave side; the source drives the master side.
interface axis_frame_sink_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_sink.sv
// Receives one IMG_W x IMG_H frame over AXI-Stream, writes it raster-order into the
// frame buffer, flags framing errors, and holds the frame until the consumer releases it.
module axis_frame_sink #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 32,
   parameter int ADDR_WIDTH = $clog2(IMG_W*IMG_H)
) (
   input  logic                  clock,
   input  logic                  reset,
   axis_frame_sink_if.slave      s,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  frame_valid,
   input  logic                  frame_release,
   output logic                  err_sof,
   output logic                  err_early_last,
   output logic                  err_late_last
);
   localparam int N = IMG_W*IMG_H;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N-1);

   typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_err_sof;
   logic                  r_err_early;
   logic                  r_err_late;

   logic                  w_ready;
   logic                  w_acc;
   logic                  w_store;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_at_last;

   // Ready comes from the state register only; gating with reset keeps it low while reset is held.
   assign w_ready   = (r_state != HOLD);
   assign s.tready  = w_ready & ~reset;
   assign w_acc     = s.tvalid & w_ready;
   // A SOF beat is stored from any accepting state and restarts the raster at address 0.
   assign w_store   = w_acc & (s.tuser | (r_state == RECV));
   assign w_idx     = s.tuser ? '0 : r_cnt;
   assign w_at_last = (w_idx == LAST_ADDR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_err_sof   <= 1'b0;
         r_err_early <= 1'b0;
         r_err_late  <= 1'b0;
      end else begin
         r_wr_en     <= 1'b0;
         r_err_sof   <= 1'b0;
         r_err_early <= 1'b0;
         r_err_late  <= 1'b0;
         if (w_store) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_idx;
            r_wr_data <= s.tdata;
         end
         case (r_state)
            HOLD: begin
               if (frame_release) r_state <= IDLE;
            end
            default: begin
               if (w_acc) begin
                  if (w_store) begin
                     r_err_sof <= s.tuser & (r_state == RECV);
                     if (s.tlast && w_at_last) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                     end else if (s.tlast) begin
                        r_err_early <= 1'b1;
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                     end else if (w_at_last) begin
                        // Frame overran without tlast: discard the rest up to tlast.
                        r_err_late <= 1'b1;
                        r_state    <= DROP;
                        r_cnt      <= '0;
                     end else begin
                        r_state <= RECV;
                        r_cnt   <= w_idx + 1'b1;
                     end
                  end else if (r_state == IDLE) begin
                     r_err_sof <= 1'b1;
                     r_state   <= s.tlast ? IDLE : DROP;
                  end else if (s.tlast) begin
                     r_state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign wr_en          = r_wr_en;
   assign wr_addr        = r_wr_addr;
   assign wr_data        = r_wr_data;
   assign frame_valid    = (r_state == HOLD);
   assign err_sof        = r_err_sof;
   assign err_early_last = r_err_early;
   assign err_late_last  = r_err_late;
endmodule

// File: tb/tb_axis_frame_sink.sv
// Randomized AXI-Stream stimulus for axis_frame_sink; a frame-level model predicts
// writes and error pulses into queues that an independent monitor drains.
module tb_axis_frame_sink;
   localparam int DW = 8;
   localparam int W  = 32;
   localparam int H  = 32;
   localparam int N  = W*H;
   localparam int AW = 10;

   logic          clock = 1'b0;
   logic          reset;
   logic          frame_release;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          frame_valid;
   logic          err_sof;
   logic          err_early_last;
   logic          err_late_last;

   always #5 clock = ~clock;

   axis_frame_sink_if #(.DATA_WIDTH(DW)) s_if ();

   axis_frame_sink #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)) dut (
      .clock          (clock),
      .reset          (reset),
      .s              (s_if),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .frame_valid    (frame_valid),
      .frame_release  (frame_release),
      .err_sof        (err_sof),
      .err_early_last (err_early_last),
      .err_late_last  (err_late_last)
   );

   typedef struct {int addr; int data;} wr_t;

   int  n_tests = 0;
   int  n_fail  = 0;
   wr_t wr_q[$];
   int  err_q[$];          // 1 = sof, 2 = early tlast, 3 = late tlast

   // Reference model: a frame is "open" after SOF and collects pixels until tlast or N.
   bit  m_open    = 0;
   bit  m_discard = 0;
   bit  m_hold    = 0;
   int  m_got     = 0;
   int  m_frames  = 0;
   int  obs_frames = 0;
   bit  fv_prev   = 0;
   int  auto_rel_k = 0;
   int  hold_cyc   = 0;
   wr_t mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string msg);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", msg, $time);
   endtask

   task automatic model_beat(input int d, input bit u, input bit l);
      if (u) begin
         if (m_open) err_q.push_back(1);
         m_open    = 1;
         m_discard = 0;
         m_got     = 0;
      end
      if (m_open) begin
         wr_q.push_back('{m_got, d});
         m_got++;
         if (l) begin
            if (m_got == N) begin
               m_hold = 1;
               m_frames++;
            end else err_q.push_back(2);
            m_open = 0;
         end else if (m_got == N) begin
            err_q.push_back(3);
            m_open    = 0;
            m_discard = 1;
         end
      end else if (!m_discard) begin
         err_q.push_back(1);
         m_discard = !l;
      end else if (l) begin
         m_discard = 0;
      end
   endtask

   task automatic pop_err(input int code, input string name);
      if (err_q.size() == 0) fail({"unexpected ", name});
      else chk(name, code, err_q.pop_front());
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clock) begin
      if (wr_en) begin
         if (wr_q.size() == 0) fail("unexpected wr_en");
         else begin
            mon_e = wr_q.pop_front();
            chk("wr_addr", int'(wr_addr), mon_e.addr);
            chk("wr_data", int'(wr_data), mon_e.data);
         end
      end
      if (err_sof)        pop_err(1, "err_sof");
      if (err_early_last) pop_err(2, "err_early_last");
      if (err_late_last)  pop_err(3, "err_late_last");
      chk("frame_valid", int'(frame_valid), int'(m_hold));
      if (frame_valid && !fv_prev) obs_frames++;
      fv_prev = frame_valid;
   end

   // One clock: check ready before the edge, advance the model on the edge, drive after it.
   task automatic tick(output bit acc);
      bit rel;
      bit exp_rdy;
      @(negedge clock);
      exp_rdy = !m_hold;
      chk("s_tready", int'(s_if.tready), int'(exp_rdy));
      acc = s_if.tvalid && exp_rdy;
      rel = frame_release;
      @(posedge clock);
      if (acc) model_beat(int'(s_if.tdata), s_if.tuser, s_if.tlast);
      if (rel) m_hold = 0;
      #1;
      if (auto_rel_k > 0) begin
         if (m_hold) begin
            hold_cyc++;
            frame_release = (hold_cyc == auto_rel_k);
         end else begin
            hold_cyc = 0;
            frame_release = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      s_if.tvalid = 1'b0;
      repeat (n) tick(acc);
   endtask

   task automatic reset_mid();
      @(negedge clock);
      #2;
      reset = 1'b1;
      wr_q.delete();
      err_q.delete();
      m_open = 0; m_discard = 0; m_hold = 0; m_got = 0; hold_cyc = 0;
      frame_release = 1'b0;
      s_if.tvalid = 1'b0;
      #1;
      chk("rst_s_tready", int'(s_if.tready), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_frame_valid", int'(frame_valid), 0);
      chk("rst_errs", int'({err_sof, err_early_last, err_late_last}), 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input int n, input bit sof, input int last_idx, input int sof2_idx,
                       input int gap, input bit ramp, input int rst_at);
      bit acc;
      int to;
      for (int i = 0; i < n; i++) begin
         if (i == rst_at) begin
            reset_mid();
            return;
         end
         while ($urandom_range(99) < gap) begin
            s_if.tvalid = 1'b0;
            tick(acc);
         end
         s_if.tvalid = 1'b1;
         s_if.tdata  = ramp ? 8'(i) : 8'($urandom);
         s_if.tuser  = (sof && i == 0) || (i == sof2_idx);
         s_if.tlast  = (i == last_idx);
         to = 0;
         do begin
            tick(acc);
            to++;
         end while (!acc && to < 4000);
         if (!acc) begin
            fail("beat accept timeout");
            s_if.tvalid = 1'b0;
            return;
         end
      end
      s_if.tvalid = 1'b0;
      s_if.tuser  = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      reset         = 1'b1;
      frame_release = 1'b0;
      s_if.tvalid   = 1'b0;
      s_if.tdata    = '0;
      s_if.tuser    = 1'b0;
      s_if.tlast    = 1'b0;
      #3;
      chk("reset_s_tready", int'(s_if.tready), 0);
      chk("reset_wr_en", int'(wr_en), 0);
      chk("reset_frame_valid", int'(frame_valid), 0);
      chk("reset_errs", int'({err_sof, err_early_last, err_late_last}), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Clean frame, constant tvalid, data = address low byte, manual release.
      send(N, 1, N-1, -1, 0, 1, -1);
      chk("fv_after_last_beat", int'(frame_valid), 1);
      chk("tready_in_hold", int'(s_if.tready), 0);
      idle(5);
      frame_release = 1'b1;
      tick(acc);
      frame_release = 1'b0;
      chk("fv_after_release", int'(frame_valid), 0);
      chk("tready_after_release", int'(s_if.tready), 1);

      // Gaps, and a second frame offered while the first is held.
      auto_rel_k = 25;
      send(N, 1, N-1, -1, 30, 0, -1);
      send(N, 1, N-1, -1, 20, 0, -1);
      idle(40);

      // Early tlast after 500 beats, then a good frame.
      auto_rel_k = 10;
      send(500, 1, 499, -1, 10, 0, -1);
      send(N, 1, N-1, -1, 5, 0, -1);
      idle(20);

      // Missing tlast: 1030 beats, tlast on the last one.
      send(1030, 1, 1029, -1, 5, 0, -1);
      idle(3);

      // No SOF, then mid-frame SOF at beat 300.
      send(11, 0, 10, -1, 0, 0, -1);
      send(N+300, 1, N+299, 300, 5, 0, -1);
      idle(20);

      // Reset at beat 600, then a fresh frame.
      send(N, 1, N-1, -1, 5, 0, 600);
      send(N, 1, N-1, -1, 5, 0, -1);
      idle(30);

      chk("wr_queue_drained", wr_q.size(), 0);
      chk("err_queue_drained", err_q.size(), 0);
      chk("frames_completed", obs_frames, m_frames);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axis_frame_sink.md
Name: axis_frame_sink

Overview:
- AXI-Stream peripheral-side receiver: accepts a pixel stream from an upstream axis main (camera/DMA/testbench source) and writes one IMG_W x IMG_H frame into the LeNet-5 input frame buffer via a simple write port.
- Validates framing: tuser marks start-of-frame, tlast marks end-of-frame.
- Holds the completed frame, with backpressure, until the conv1 stage releases it.

Parameters:
- DATA_WIDTH, 8, pixel width; matches axis_if DATA_WIDTH.
- IMG_W, 32, frame width in pixels.
- IMG_H, 32, frame height in pixels.
- ADDR_WIDTH, $clog2(IMG_W*IMG_H) = 10, frame buffer address width.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- s_tdata  input  DATA_WIDTH  pixel data.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  sink ready.
- s_tlast  input  1  last pixel of frame.
- s_tuser  input  1  first pixel of frame (SOF).
- wr_en  output  1  frame buffer write strobe.
- wr_addr  output  ADDR_WIDTH  raster address, row*IMG_W+col.
- wr_data  output  DATA_WIDTH  pixel written.
- frame_valid  output  1  complete frame resident in buffer.
- frame_release  input  1  one-cycle pulse from consumer; frees the buffer.
- err_sof  output  1  pulse: missing or unexpected SOF.
- err_early_last  output  1  pulse: tlast before N=IMG_W*IMG_H pixels.
- err_late_last  output  1  pulse: N pixels received without tlast.

Behaviour:
- Beat accepted when s_tvalid && s_tready. tkeep/tstrb are not ported and are ignored.
- Reset (async assert, sync release): state IDLE, pixel count 0. All outputs are 0, including s_tready while reset is high.
- s_tready is decoded from the state register only: 1 in IDLE, RECV and DROP; 0 in HOLD. It has no combinational path from s_tvalid.
- Write port is registered, 1-cycle latency: an accepted beat to be stored gives wr_en=1 with its addr/data on the next cycle. Discarded beats produce no wr_en.
- Error pulses are registered, one cycle high, and appear on the cycle after the offending beat.
- States:
  - IDLE:
    - Beat with tuser=1: write addr 0, count=1, go RECV. If tlast is also set and N>1: err_early_last, stay IDLE.
    - Beat with tuser=0: discard, err_sof. Go DROP, or stay IDLE if tlast.
  - RECV (count = next address):
    - Beat with tuser=1 mid-frame: err_sof, resync, write addr 0, count=1.
    - Otherwise write addr=count, then:
      - tlast && count==N-1: go HOLD.
      - tlast && count<N-1: err_early_last, go IDLE. Partial frame abandoned, no frame_valid.
      - !tlast && count==N-1: err_late_last, go DROP. Frame abandoned.
      - Else: count+1.
  - DROP: accept and discard beats.
    - tlast: go IDLE.
    - tuser=1 beat: treated as a new SOF, same handling as IDLE with tuser=1.
  - HOLD:
    - frame_valid=1, s_tready=0.
    - frame_release: go IDLE next cycle, frame_valid 0 that cycle.
    - frame_release outside HOLD is ignored.
- frame_valid rises the cycle after the final beat handshake, coincident with the final wr_en. The consumer may read from the cycle after that.
- count never exceeds N-1; no wrap-around occurs, because every path out of RECV at N-1 resets it.
- Reset mid-frame: immediate return to IDLE, partial data abandoned, no error pulses.

Test Plan:
- Clean frame: 1024 beats, tdata=addr[7:0], tuser on beat 0, tlast on beat 1023, tvalid constant -> 1024 wr_en, addr 0..1023 in order. frame_valid=1 one cycle after the last beat, s_tready=0. Pulse frame_release -> frame_valid=0, s_tready=1 next cycle.
- Backpressure and bubbles: random tvalid gaps during the frame, second frame offered during HOLD -> no beat of frame 2 accepted until release, then frame 2 written from addr 0.
- Early tlast at beat 500 -> err_early_last one pulse, 500 writes, no frame_valid. Next good frame is received intact.
- Missing tlast: 1030 beats, tlast on 1029 -> err_late_last after beat 1023, beats 1024..1029 discarded, no frame_valid, state IDLE afterwards.
- No SOF: 10 beats tuser=0 then tlast -> one err_sof, zero writes. Mid-frame tuser at beat 300 -> err_sof, writes restart at addr 0.
- Reset asserted at beat 600 -> s_tready, wr_en, frame_valid and errors go 0 asynchronously. After release, a fresh full frame completes normally.
